// File: rtl/auto_shutdown_multizone.sv
// auto_shutdown_multizone: per-zone inactivity timers with pulse/held shutdown; optional warning under `WARN_EN
module auto_shutdown_multizone #(
  parameter int N_ZONES   = 4,
  parameter int CNT_W     = 16,
  parameter int DEFAULT_T = 30000,
  parameter int WARN_CYC  = 1000,
  localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] enable,
  input  logic [N_ZONES-1:0] presenca,
  input  logic               level_mode,
  input  logic               cfg_we,
  input  logic [ZW-1:0]      cfg_zone,
  input  logic [CNT_W-1:0]   cfg_data,
  output logic [N_ZONES-1:0] shutdown,
  output logic [N_ZONES-1:0] warn,
  output logic               any_shutdown
);
  typedef enum logic [1:0] {S_IDLE, S_COUNTING, S_FIRE, S_HOLD} state_t;
  state_t           r_state  [N_ZONES];
  state_t           w_nstate [N_ZONES];
  logic [CNT_W-1:0] r_cnt    [N_ZONES];
  logic [CNT_W-1:0] w_ncnt   [N_ZONES];
  logic [CNT_W-1:0] r_t      [N_ZONES];
  logic [CNT_W-1:0] w_tm1    [N_ZONES];
  // state, counters and timeout registers; out-of-range cfg_zone matches no zone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < N_ZONES; z++) begin
        r_state[z] <= S_IDLE;
        r_cnt[z]   <= '0;
        r_t[z]     <= CNT_W'(DEFAULT_T);
      end
    end else begin
      for (int z = 0; z < N_ZONES; z++) begin
        r_state[z] <= w_nstate[z];
        r_cnt[z]   <= w_ncnt[z];
        if (cfg_we && cfg_zone == ZW'(z)) r_t[z] <= cfg_data;
      end
    end
  end
  // next-state per zone; a programmed timeout of 0 behaves as 1, presence beats timeout
  always_comb begin
    for (int z = 0; z < N_ZONES; z++) begin
      w_tm1[z]    = (r_t[z] == '0) ? '0 : r_t[z] - 1'b1;
      w_nstate[z] = S_IDLE;
      w_ncnt[z]   = '0;
      case (r_state[z])
        S_IDLE:     w_nstate[z] = (enable[z] && !presenca[z]) ? S_COUNTING : S_IDLE;
        S_COUNTING: begin
          if (!presenca[z] && enable[z]) begin
            w_nstate[z] = (r_cnt[z] >= w_tm1[z]) ? S_FIRE : S_COUNTING;
            w_ncnt[z]   = (r_cnt[z] >= w_tm1[z]) ? '0 : r_cnt[z] + 1'b1;
          end
        end
        S_FIRE:     w_nstate[z] = (level_mode && !presenca[z] && enable[z]) ? S_HOLD : S_IDLE;
        S_HOLD:     w_nstate[z] = (level_mode && !presenca[z] && enable[z]) ? S_HOLD : S_IDLE;
        default:    w_nstate[z] = S_IDLE;
      endcase
    end
  end
  // Moore shutdown decode
  always_comb begin
    for (int z = 0; z < N_ZONES; z++)
      shutdown[z] = (r_state[z] == S_FIRE) || (r_state[z] == S_HOLD);
  end
  assign any_shutdown = |shutdown;
`ifdef WARN_EN
  localparam logic [CNT_W-1:0] WC = CNT_W'(WARN_CYC);
  logic [CNT_W-1:0] w_teff [N_ZONES];
  // warning while counting within WARN_CYC of the effective timeout, threshold floored at 0
  always_comb begin
    for (int z = 0; z < N_ZONES; z++) begin
      w_teff[z] = (r_t[z] == '0) ? CNT_W'(1) : r_t[z];
      warn[z]   = (r_state[z] == S_COUNTING) && (r_cnt[z] >= ((w_teff[z] > WC) ? w_teff[z] - WC : '0));
    end
  end
`else
  assign warn = '0;
`endif
endmodule
